// File: rtl/bus_arbiter.sv
// bus_arbiter: sequenced owner of the CPU bus for the fetch and
// load/store requesters, with wait states, timeout and error acks.
module bus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned MAX_DATA_RUN   = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        fetch_req,
  input  logic [31:0] fetch_address,
  output logic        fetch_ack,
  output logic [31:0] fetch_rdata,
  input  logic        data_req,
  input  logic [31:0] data_address,
  input  logic        data_write,
  input  logic [1:0]  data_cycle_width,
  input  logic [31:0] data_wdata,
  output logic        data_ack,
  output logic [31:0] data_rdata,
  output logic        ack_error,
  output logic        grant_data,
  output logic [31:0] bus_address,
  output logic [1:0]  bus_cycle_width,
  output logic [31:0] bus_data_out,
  output logic        bus_read,
  output logic        bus_write,
  input  logic [31:0] bus_data_in,
  input  logic        bus_ready,
  input  logic        bus_error
);

  localparam logic [1:0] CW_LONG = 2'd2;
  localparam int TW =
    (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam int RW = $clog2(MAX_DATA_RUN + 1);
  localparam logic [TW-1:0] TMO_LAST =
    TW'(TIMEOUT_CYCLES - 1);
  localparam logic [RW-1:0] RUN_MAX = RW'(MAX_DATA_RUN);
  localparam bit TMO_ON = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {
    IDLE,
    BUS,
    ACK
  } state_t;

  state_t        state, state_n;
  logic [TW-1:0] tmo, tmo_n;
  logic [RW-1:0] run, run_n;

  logic        fetch_ack_n, data_ack_n, ack_error_n;
  logic [31:0] fetch_rdata_n, data_rdata_n;
  logic        grant_data_n;
  logic [31:0] address_n, data_out_n;
  logic [1:0]  cycle_width_n;
  logic        read_n, write_n;

  logic f_req, d_req, pick_f, timed_out;

  // The port acked this cycle still shows its old request; ignore it.
  assign f_req = fetch_req & ~((state == ACK) & ~grant_data);
  assign d_req = data_req & ~((state == ACK) & grant_data);
  assign pick_f = f_req & (~d_req | (run == RUN_MAX));
  assign timed_out = TMO_ON & (tmo == TMO_LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      tmo             <= '0;
      run             <= '0;
      fetch_ack       <= 1'b0;
      data_ack        <= 1'b0;
      ack_error       <= 1'b0;
      fetch_rdata     <= '0;
      data_rdata      <= '0;
      grant_data      <= 1'b0;
      bus_address     <= '0;
      bus_cycle_width <= '0;
      bus_data_out    <= '0;
      bus_read        <= 1'b0;
      bus_write       <= 1'b0;
    end else begin
      state           <= state_n;
      tmo             <= tmo_n;
      run             <= run_n;
      fetch_ack       <= fetch_ack_n;
      data_ack        <= data_ack_n;
      ack_error       <= ack_error_n;
      fetch_rdata     <= fetch_rdata_n;
      data_rdata      <= data_rdata_n;
      grant_data      <= grant_data_n;
      bus_address     <= address_n;
      bus_cycle_width <= cycle_width_n;
      bus_data_out    <= data_out_n;
      bus_read        <= read_n;
      bus_write       <= write_n;
    end
  end

  always_comb begin
    state_n       = state;
    tmo_n         = tmo;
    run_n         = run;
    fetch_ack_n   = 1'b0;
    data_ack_n    = 1'b0;
    ack_error_n   = 1'b0;
    fetch_rdata_n = fetch_rdata;
    data_rdata_n  = data_rdata;
    grant_data_n  = grant_data;
    address_n     = bus_address;
    cycle_width_n = bus_cycle_width;
    data_out_n    = bus_data_out;
    read_n        = 1'b0;
    write_n       = 1'b0;
    unique case (state)
      BUS: begin
        if (bus_ready | bus_error | timed_out) begin
          state_n     = ACK;
          fetch_ack_n = ~grant_data;
          data_ack_n  = grant_data;
          ack_error_n = bus_error | ~bus_ready;
          if (bus_ready | bus_error) begin
            if (grant_data)
              data_rdata_n = bus_data_in;
            else
              fetch_rdata_n = bus_data_in;
          end
        end else begin
          tmo_n   = tmo + TW'(1);
          read_n  = bus_read;
          write_n = bus_write;
        end
      end
      default: begin
        state_n = IDLE;
        if (f_req | d_req) begin
          state_n      = BUS;
          tmo_n        = '0;
          grant_data_n = ~pick_f;
          if (pick_f) begin
            address_n     = fetch_address;
            cycle_width_n = CW_LONG;
            data_out_n    = '0;
            read_n        = 1'b1;
            run_n         = '0;
          end else begin
            address_n     = data_address;
            cycle_width_n = data_cycle_width;
            data_out_n    = data_wdata;
            read_n        = ~data_write;
            write_n       = data_write;
            if (!f_req)
              run_n = '0;
            else if (run != RUN_MAX)
              run_n = run + RW'(1);
          end
        end
      end
    endcase
  end

endmodule
